// File: rtl/arithm_div_seq.sv
// Multi-cycle restoring divider (quotient/remainder) behind a valid/ready handshake.
// Optional macro DIV_SIGNED_EN selects two's complement operands; the default build is unsigned.
module arithm_div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_sel,
  input  logic [WIDTH-1:0] i_first_op,
  input  logic [WIDTH-1:0] i_second_op,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_dbz,
  output logic             o_ovf
);

  // state | meaning
  // IDLE  | waiting for a request, o_ready = 1
  // CALC  | one restoring iteration per cycle, WIDTH cycles
  // DONE  | result held on o_data until the consumer takes it
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sel_rem_q;

  logic             accept, sel_ok, dvs_zero, last_iter, ovf_case;
  logic             short_go, short_dbz, short_ovf;
  logic [WIDTH-1:0] short_data;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] rem_nx, quo_nx, q_res, r_res, calc_data;

  assign o_ready  = (state == IDLE);
  assign o_valid  = (state == DONE);
  assign accept   = i_valid && o_ready;
  assign sel_ok   = (i_sel[2:1] == 2'b10);
  assign dvs_zero = (i_second_op == '0);

`ifdef DIV_SIGNED_EN
  logic a_sign, b_sign, neg_q_q, neg_r_q;

  assign a_sign   = i_first_op[WIDTH-1];
  assign b_sign   = i_second_op[WIDTH-1];
  // MIN magnitude still fits in WIDTH bits when read as unsigned
  assign a_mag    = a_sign ? -i_first_op : i_first_op;
  assign b_mag    = b_sign ? -i_second_op : i_second_op;
  assign ovf_case = i_first_op[WIDTH-1] && (i_first_op[WIDTH-2:0] == '0) && (&i_second_op);
  assign q_res    = neg_q_q ? -quo_nx : quo_nx;
  assign r_res    = neg_r_q ? -rem_nx : rem_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (accept) begin
      neg_q_q <= a_sign ^ b_sign;
      neg_r_q <= a_sign;
    end
  end
`else
  assign a_mag    = i_first_op;
  assign b_mag    = i_second_op;
  assign ovf_case = 1'b0;
  assign q_res    = quo_nx;
  assign r_res    = rem_nx;
`endif

  // One restoring step; the WIDTH+1 bit trial keeps the borrow as its sign.
  assign rem_sh    = {rem_q, quo_q[WIDTH-1]};
  assign trial     = rem_sh - {1'b0, dvs_q};
  assign rem_nx    = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_nx    = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  assign calc_data = sel_rem_q ? r_res : q_res;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // Requests that finish at the accept edge without iterating.
  always_comb begin
    short_go   = 1'b0;
    short_data = '0;
    short_dbz  = 1'b0;
    short_ovf  = 1'b0;
    if (!sel_ok) begin
      short_go = 1'b1;
    end else if (dvs_zero) begin
      short_go   = 1'b1;
      short_data = i_sel[0] ? i_first_op : '1;
      short_dbz  = 1'b1;
    end else if (ovf_case) begin
      short_go   = 1'b1;
      short_data = i_sel[0] ? '0 : i_first_op;
      short_ovf  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = short_go ? DONE : CALC;
      CALC: if (last_iter) state_nx = DONE;
      DONE: if (i_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      sel_rem_q <= 1'b0;
      o_data    <= '0;
      o_dbz     <= 1'b0;
      o_ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sel_rem_q <= i_sel[0];
            if (short_go) begin
              o_data <= short_data;
              o_dbz  <= short_dbz;
              o_ovf  <= short_ovf;
            end else begin
              rem_q <= '0;
              quo_q <= a_mag;
              dvs_q <= b_mag;
              cnt_q <= '0;
            end
          end
        end
        CALC: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) begin
            o_data <= calc_data;
            o_dbz  <= 1'b0;
            o_ovf  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arithm_div_seq.sv
// Self-checking bench for arithm_div_seq: directed table, corner sequences, random vs. model.
// Follows DIV_SIGNED_EN the same way the design does.
module tb_arithm_div_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_ready = 1'b0;
  logic [2:0]   i_sel = 3'b000;
  logic [W-1:0] i_first_op = '0;
  logic [W-1:0] i_second_op = '0;
  logic         o_ready, o_valid, o_dbz, o_ovf;
  logic [W-1:0] o_data;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  arithm_div_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_sel(i_sel), .i_first_op(i_first_op), .i_second_op(i_second_op),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_dbz(o_dbz), .o_ovf(o_ovf)
  );

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] a, b, d;
    logic        dbz, ovf;
    int          lat;
    string       nm;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] sel, input logic [31:0] a, b, d,
                     input logic dbz, ovf, input int lat, input string nm);
    vec_t v;
    v.sel = sel; v.a = a; v.b = b; v.d = d; v.dbz = dbz; v.ovf = ovf; v.lat = lat; v.nm = nm;
    tbl.push_back(v);
  endtask

  // Reference: latency is counted in edges after the accept edge.
  task automatic model(input logic [2:0] sel, input logic [31:0] a, b,
                       output logic [31:0] d, output logic dbz, ovf, output int lat);
    d = 0; dbz = 0; ovf = 0; lat = W;
    if (sel != 3'b100 && sel != 3'b101) begin
      lat = 0;
    end else if (b == 0) begin
      d = (sel == 3'b101) ? a : 32'hFFFF_FFFF; dbz = 1; lat = 0;
    end else begin
`ifdef DIV_SIGNED_EN
      int sa, sb;
      sa = a; sb = b;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        d = (sel == 3'b101) ? 32'h0 : 32'h8000_0000; ovf = 1; lat = 0;
      end else begin
        d = (sel == 3'b101) ? 32'(sa % sb) : 32'(sa / sb);
      end
`else
      d = (sel == 3'b101) ? a % b : a / b;
`endif
    end
  endtask

  task automatic start_op(input logic [2:0] sel, input logic [31:0] a, b);
    int n = 0;
    while (!o_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk("ready_wait", {63'd0, o_ready}, 64'd1);
    i_valid = 1; i_sel = sel; i_first_op = a; i_second_op = b;
    @(posedge clk); #1;
    i_valid = 0; i_first_op = $urandom; i_second_op = $urandom; i_sel = 3'($urandom);
  endtask

  task automatic wait_res(output int n);
    n = 0;
    while (!o_valid && n < 100) begin @(posedge clk); #1; n++; end
  endtask

  task automatic handoff();
    i_ready = 1;
    @(posedge clk); #1;
    i_ready = 0;
    chk("handoff_ready", {63'd0, o_ready}, 64'd1);
    chk("handoff_valid", {63'd0, o_valid}, 64'd0);
  endtask

  task automatic run(input vec_t v);
    int n;
    start_op(v.sel, v.a, v.b);
    wait_res(n);
    chk({v.nm, "_lat"}, 64'(n), 64'(v.lat));
    chk({v.nm, "_data"}, {32'd0, o_data}, {32'd0, v.d});
    chk({v.nm, "_dbz"}, {63'd0, o_dbz}, {63'd0, v.dbz});
    chk({v.nm, "_ovf"}, {63'd0, o_ovf}, {63'd0, v.ovf});
    handoff();
  endtask

  initial begin
    vec_t v;
    int n;
    logic [31:0] a, b, d;
    logic dbz, ovf;
    logic [2:0] sel;
    int lat;

    add(3'b100, 32'd100, 32'd7, 32'd14, 0, 0, W, "div_100_7");
    add(3'b101, 32'd100, 32'd7, 32'd2, 0, 0, W, "rem_100_7");
    add(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, 0, "div_by_zero");
    add(3'b101, 32'd5, 32'd0, 32'd5, 1, 0, 0, "rem_by_zero");
    add(3'b000, 32'd100, 32'd7, 32'd0, 0, 0, 0, "bad_sel_000");
    add(3'b111, 32'd100, 32'd7, 32'd0, 0, 0, 0, "bad_sel_111");
    add(3'b100, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 0, 0, W, "div_max_1");
    add(3'b100, 32'd1000, 32'd1000, 32'd1, 0, 0, W, "div_equal");
    add(3'b101, 32'd3, 32'd10, 32'd3, 0, 0, W, "rem_small");
`ifdef DIV_SIGNED_EN
    add(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 0, W, "div_m7_2");
    add(3'b101, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, 0, W, "rem_m7_2");
    add(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1, 0, "div_min_m1");
    add(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, 1, 0, "rem_min_m1");
`else
    add(3'b100, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 0, 0, W, "div_big_2");
    add(3'b101, 32'hFFFF_FFF9, 32'd2, 32'h1, 0, 0, W, "rem_big_2");
    add(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, 0, W, "div_msb_max");
    add(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, W, "rem_msb_max");
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {63'd0, o_ready}, 64'd1);
    chk("rst_valid", {63'd0, o_valid}, 64'd0);
    chk("rst_data", {32'd0, o_data}, 64'd0);
    chk("rst_flags", {62'd0, o_dbz, o_ovf}, 64'd0);
    rst_n = 1;

    foreach (tbl[i]) run(tbl[i]);

    // Backpressure: result held, requests ignored while DONE
    start_op(3'b100, 32'd100, 32'd7);
    wait_res(n);
    chk("bp_lat", 64'(n), 64'(W));
    for (int i = 0; i < 10; i++) begin
      i_valid = 1; i_sel = 3'b101; i_first_op = $urandom; i_second_op = 32'd3;
      @(posedge clk); #1;
      chk("bp_valid", {63'd0, o_valid}, 64'd1);
      chk("bp_ready", {63'd0, o_ready}, 64'd0);
      chk("bp_data", {32'd0, o_data}, 64'd14);
    end
    i_valid = 0;
    handoff();
    @(posedge clk); #1;
    chk("bp_no_stale_accept", {63'd0, o_ready}, 64'd1);
    chk("bp_data_after", {32'd0, o_data}, 64'd14);

    // Reset mid-CALC at count 15, with nonzero outputs from a prior op
    v = tbl[2];
    run(v);
    start_op(3'b100, 32'd100, 32'd7);
    repeat (15) @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    chk("midrst_ready", {63'd0, o_ready}, 64'd1);
    chk("midrst_valid", {63'd0, o_valid}, 64'd0);
    chk("midrst_data", {32'd0, o_data}, 64'd0);
    chk("midrst_flags", {62'd0, o_dbz, o_ovf}, 64'd0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    v = tbl[6];
    run(v);

    // Back-to-back: second request presented during the handoff cycle
    start_op(3'b100, 32'd1000, 32'd3);
    wait_res(n);
    chk("b2b_first", {32'd0, o_data}, 64'd333);
    i_ready = 1; i_valid = 1; i_sel = 3'b101; i_first_op = 32'd77; i_second_op = 32'd5;
    @(posedge clk); #1;
    i_ready = 0;
    chk("b2b_not_taken", {63'd0, o_ready}, 64'd1);
    @(posedge clk); #1;
    i_valid = 0; i_first_op = $urandom; i_second_op = $urandom;
    chk("b2b_taken", {63'd0, o_ready}, 64'd0);
    wait_res(n);
    chk("b2b_lat", 64'(n), 64'(W));
    chk("b2b_second", {32'd0, o_data}, 64'd2);
    handoff();

    // Random operations against the reference model
    for (int k = 0; k < 150; k++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1, 2: b = $urandom_range(1, 255);
        3: a = $urandom_range(0, 1000);
`ifdef DIV_SIGNED_EN
        4: begin a = 32'h8000_0000; b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : b; end
        5: b = -$urandom_range(1, 300);
`endif
        default: ;
      endcase
      sel = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 5));
      model(sel, a, b, d, dbz, ovf, lat);
      v.sel = sel; v.a = a; v.b = b; v.d = d; v.dbz = dbz; v.ovf = ovf; v.lat = lat;
      v.nm = $sformatf("rand%0d", k);
      run(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arithm_div_seq.md
# arithm_div_seq

Multi-cycle restoring divider for the ALU datapath, producing quotient or remainder over WIDTH clock cycles behind a valid/ready handshake. It reuses the arithmetic select codes (DIV = 3'b100, REM = 3'b101), so the control unit can route these two operations here instead of to the single-cycle combinational divide path. This removes the long combinational `/` and `%` chains from the critical path. Operands are captured once and the result is held until the consumer takes it.

## Interface

- WIDTH, 32, operand/result width (equals `REG_WIDTH`)
- CNT_W, $clog2(WIDTH+1), iteration counter width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  request present
- o_ready  output  1  block idle, can accept a request
- i_sel  input  3  3'b100 = quotient, 3'b101 = remainder
- i_first_op  input  WIDTH  dividend
- i_second_op  input  WIDTH  divisor
- o_valid  output  1  result available
- i_ready  input  1  consumer takes result
- o_data  output  WIDTH  quotient or remainder
- o_dbz  output  1  divisor was zero
- o_ovf  output  1  signed overflow (MIN / -1); always 0 without DIV_SIGNED_EN

## Operation

- Clock and reset are fixed for this block: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- States: IDLE, CALC, DONE. `o_ready` is 1 only in IDLE. `o_valid` is 1 only in DONE.
- IDLE → accept when i_valid && o_ready. On accept, capture i_sel, operand magnitudes, sign bits, and divisor-zero flag.
  - Divisor == 0 → DONE. Quotient request gives o_data = all ones; remainder request gives o_data = dividend. o_dbz = 1.
  - i_sel not 10x → DONE, o_data = 0, o_dbz = 0, o_ovf = 0.
  - Otherwise → CALC with count = 0, partial remainder = 0, quotient register = dividend magnitude.
- CALC, one iteration per cycle:
  - Shift {rem, quo} left by 1.
  - Trial subtract: rem − divisor, computed WIDTH+1 bits wide.
  - Non-negative trial → rem = trial, quo LSB = 1. Negative trial → rem unchanged, quo LSB = 0.
  - count increments each iteration. After iteration WIDTH (count reaches WIDTH) → DONE.
- On entering DONE from CALC, register o_data = selected quotient or remainder, after sign fix-up when signed mode is enabled.
- DONE: outputs held stable until i_ready. On o_valid && i_ready → IDLE.
  - No new request is accepted in that same cycle; o_ready rises the next cycle.
- i_valid while busy is ignored; the requester must hold its request.
- Operand inputs are don't-care after the capture edge.

## Timing

- Reset (async assert, sync deassert handled upstream): state = IDLE, o_ready = 1, o_valid = 0, o_data = 0, o_dbz = 0, o_ovf = 0, counter = 0.
- Normal latency: o_valid is high after the WIDTH-th rising edge following the accept edge (32 cycles at default width).
- Divide-by-zero and illegal-select latency: o_valid is high after the first edge following accept.
- Throughput: at most one operation per WIDTH+2 cycles (accept, WIDTH iterations, handoff).
- rst_n asserted mid-CALC or mid-DONE: operation is discarded immediately with no result; outputs go to their reset values.
- o_data, o_dbz and o_ovf change only on the DONE entry edge and the reset edge.

## Configuration

- DIV_SIGNED_EN defined:
  - Operands are two's complement. The core iterates on magnitudes.
  - Quotient sign = sign(a) XOR sign(b). Remainder takes the sign of the dividend, with truncation toward zero.
  - MIN / −1 → quotient = MIN, remainder = 0, o_ovf = 1, 1-cycle latency.
  - Divide by zero → quotient all ones, remainder = dividend (unchanged).
- DIV_SIGNED_EN undefined:
  - Operands are unsigned; there is no sign logic or overflow detect.
  - o_ovf is tied to 0.

## Test plan

- Unsigned 100 / 7, sel 3'b100 → o_valid after 32 edges, o_data = 14, o_dbz = 0. Same operands with sel 3'b101 → o_data = 2.
- 5 / 0: sel DIV → o_data = 0xFFFFFFFF, o_dbz = 1, o_valid after 1 edge. sel REM → o_data = 5.
- With DIV_SIGNED_EN: −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, o_ovf = 1.
- Backpressure: hold i_ready = 0 for 10 cycles in DONE → o_data and o_valid stable, o_ready = 0, new i_valid ignored. Raise i_ready → IDLE next edge.
- Reset at CALC count 15 → outputs zero, o_ready = 1 immediately. A following 0xFFFFFFFF / 1 → 0xFFFFFFFF.
- Back-to-back: second request presented during the handoff cycle is not accepted until o_ready = 1. Its result is correct and independent of the first.
